// File: rtl/fifo_pkg.sv
// Shared constants and types for the flow-controlled FIFO slice.
// Build option: define FIFO_FWFT_EN for first-word fall-through reads.
package fifo_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 3;
  localparam int unsigned DefAfRst = 6;
  localparam int unsigned DefAeRst = 2;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int unsigned cnt_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
    logic aempty;
  } flags_t;

endpackage

// File: rtl/fifo_flow_ctrl_if.sv
// Push/pop, threshold-programming and status bundle of the flow-controlled FIFO.
interface fifo_flow_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) ();

  localparam int unsigned CntW = cnt_w(ADDR_W);

  logic              write;
  logic [DATA_W-1:0] data_in_push;
  logic              read;
  logic [DATA_W-1:0] data_out_pop;
  logic              data_valid;
  logic              thr_load;
  logic [CntW-1:0]   af_thresh_in;
  logic [CntW-1:0]   ae_thresh_in;
  logic              err_clr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_full;
  logic              almost_empty;
  logic              fifo_pause;
  logic              fifo_error;
  logic              err_sticky;
  logic [CntW-1:0]   count;

  modport master (
    output write, data_in_push, read, thr_load, af_thresh_in, ae_thresh_in, err_clr,
    input  data_out_pop, data_valid, fifo_empty, fifo_full, almost_full, almost_empty,
    input  fifo_pause, fifo_error, err_sticky, count
  );

  modport slave (
    input  write, data_in_push, read, thr_load, af_thresh_in, ae_thresh_in, err_clr,
    output data_out_pop, data_valid, fifo_empty, fifo_full, almost_full, almost_empty,
    output fifo_pause, fifo_error, err_sticky, count
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W storage: synchronous write port, combinational read port.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Storage is deliberately not reset; stale words are never observable.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Single-clock FIFO with programmable thresholds, hysteretic pause and error reporting.
// Build option: FIFO_FWFT_EN selects first-word fall-through instead of a registered read.
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned AF_RST = DefAfRst,
  parameter int unsigned AE_RST = DefAeRst
) (
  input logic             clk,
  input logic             reset,
  fifo_flow_ctrl_if.slave bus
);

  localparam int unsigned   CntW   = cnt_w(ADDR_W);
  localparam logic [CntW-1:0] DepthC = CntW'(2**ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   af_q, ae_q;
  flags_t            flags_q, flags_d;
  logic              pause_q, pause_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic              push_ok, pop_ok;
  logic [DATA_W-1:0] rd_data;

  fifo_mem_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in_push),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    pop_ok  = bus.read && !flags_q.empty;
    // A push at full only fits if a pop frees a slot on the same edge.
    push_ok = bus.write && (!flags_q.full || pop_ok);
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);

    flags_d.empty  = (count_d == '0);
    flags_d.full   = (count_d == DepthC);
    flags_d.afull  = (count_d >= af_q);
    flags_d.aempty = (count_d != '0) && (count_d <= ae_q);

    pause_d = pause_q;
    if (count_d >= af_q) begin
      pause_d = 1'b1;
    end else if (count_d <= ae_q) begin
      pause_d = 1'b0;
    end

    err_d    = (bus.write && !push_ok) || (bus.read && !pop_ok);
    sticky_d = err_d ? 1'b1 : (bus.err_clr ? 1'b0 : sticky_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '{empty: 1'b1, full: 1'b0, afull: 1'b0, aempty: 1'b0};
      pause_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      af_q     <= CntW'(AF_RST);
      ae_q     <= CntW'(AE_RST);
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q  <= count_d;
      flags_q  <= flags_d;
      pause_q  <= pause_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      if (bus.thr_load) begin
        af_q <= bus.af_thresh_in;
        ae_q <= bus.ae_thresh_in;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out_pop = flags_q.empty ? '0 : rd_data;
  assign bus.data_valid   = !flags_q.empty;
`else
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop_ok;
      if (pop_ok) begin
        dout_q <= rd_data;
      end
    end
  end

  assign bus.data_out_pop = dout_q;
  assign bus.data_valid   = valid_q;
`endif

  assign bus.fifo_empty   = flags_q.empty;
  assign bus.fifo_full    = flags_q.full;
  assign bus.almost_full  = flags_q.afull;
  assign bus.almost_empty = flags_q.aempty;
  assign bus.fifo_pause   = pause_q;
  assign bus.fifo_error   = err_q;
  assign bus.err_sticky   = sticky_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Bench for fifo_flow_ctrl: directed scenarios plus random traffic against a queue model.
module tb_fifo_flow_ctrl;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF0 = 6;
  localparam int AE0 = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_flow_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fifo_flow_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .AF_RST (AF0),
    .AE_RST (AE0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents as a queue, flags from its size.
  int mq[$];
  int m_af, m_ae, m_dout;
  bit m_pause, m_err, m_sticky, m_afl, m_ael, m_valid;

  function automatic logic [19:0] obs();
    return {bus.fifo_empty, bus.fifo_full, bus.almost_full, bus.almost_empty, bus.fifo_pause,
            bus.fifo_error, bus.err_sticky, bus.count, bus.data_valid, bus.data_out_pop};
  endfunction

  function automatic logic [19:0] expv();
    int n = mq.size();
    logic [7:0] d;
    logic v;
`ifdef FIFO_FWFT_EN
    v = (n != 0);
    d = (n != 0) ? 8'(mq[0]) : 8'h00;
`else
    v = m_valid;
    d = 8'(m_dout);
`endif
    return {n == 0, n == DEPTH, m_afl, m_ael, m_pause, m_err, m_sticky, 4'(n), v, d};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_af = AF0; m_ae = AE0; m_dout = 0;
    m_pause = 0; m_err = 0; m_sticky = 0; m_afl = 0; m_ael = 0; m_valid = 0;
  endtask

  task automatic step(input bit w, input bit r, input int d, input bit clr = 0,
                      input bit ld = 0, input int af = 0, input int ae = 0);
    bit pop_ok, push_ok;
    int n;
    bus.write = w; bus.read = r; bus.data_in_push = 8'(d);
    bus.err_clr = clr; bus.thr_load = ld;
    bus.af_thresh_in = 4'(af); bus.ae_thresh_in = 4'(ae);
    @(posedge clk);
    #1;
    pop_ok  = r && (mq.size() != 0);
    push_ok = w && ((mq.size() != DEPTH) || pop_ok);
    m_err   = (w && !push_ok) || (r && !pop_ok);
    m_valid = pop_ok;
    if (pop_ok) m_dout = mq.pop_front();
    if (push_ok) mq.push_back(d & 'hff);
    n = mq.size();
    m_afl = (n >= m_af);
    m_ael = (n != 0) && (n <= m_ae);
    if (n >= m_af) m_pause = 1;
    else if (n <= m_ae) m_pause = 0;
    m_sticky = m_err ? 1'b1 : (clr ? 1'b0 : m_sticky);
    if (ld) begin
      m_af = af;
      m_ae = ae;
    end
    bus.write = 0; bus.read = 0; bus.err_clr = 0; bus.thr_load = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    reset = 1'b1;
    model_reset();
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL reset_vec: got %h want %h", obs(), expv());
    end
    n_vec++;
    if (bus.fifo_empty !== 1'b1 || bus.count !== 4'd0 || bus.data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: empty=%b count=%0d valid=%b want 1/0/0",
               bus.fifo_empty, bus.count, bus.data_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 'h10 + i);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL fill[%0d]: got %h want %h", i, obs(), expv());
      end
      n_vec++;
      if (bus.almost_full !== (i >= 5)) begin
        n_err++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.almost_full, i >= 5);
      end
    end
    n_vec++;
    if (bus.fifo_full !== 1'b1 || bus.fifo_pause !== 1'b1 || bus.count !== 4'd8) begin
      n_err++;
      $display("FAIL fill_full: full=%b pause=%b count=%0d want 1/1/8",
               bus.fifo_full, bus.fifo_pause, bus.count);
    end
    step(1, 0, 'h99);
    n_vec++;
    if (bus.fifo_error !== 1'b1 || bus.err_sticky !== 1'b1 || bus.count !== 4'd8) begin
      n_err++;
      $display("FAIL overflow: err=%b sticky=%b count=%0d want 1/1/8",
               bus.fifo_error, bus.err_sticky, bus.count);
    end
    step(0, 0, 0);
    n_vec++;
    if (obs() !== expv() || bus.fifo_error !== 1'b0) begin
      n_err++; $display("FAIL overflow_pulse: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL drain[%0d]: got %h want %h", i, obs(), expv());
      end
`ifndef FIFO_FWFT_EN
      n_vec++;
      if (bus.data_out_pop !== 8'(8'h10 + i) || bus.data_valid !== 1'b1) begin
        n_err++;
        $display("FAIL drain_data[%0d]: got %h/%b want %h/1", i, bus.data_out_pop,
                 bus.data_valid, 8'h10 + i);
      end
`endif
      n_vec++;
      if (bus.fifo_pause !== (i < 5)) begin
        n_err++; $display("FAIL drain_pause[%0d]: got %b want %b", i, bus.fifo_pause, i < 5);
      end
    end
    step(0, 0, 0);
    n_vec++;
    if (bus.fifo_empty !== 1'b1 || bus.almost_empty !== 1'b0 || bus.data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drained: empty=%b ae=%b valid=%b want 1/0/0",
               bus.fifo_empty, bus.almost_empty, bus.data_valid);
    end
    step(0, 1, 0);
    n_vec++;
    if (bus.fifo_error !== 1'b1 || obs() !== expv()) begin
      n_err++; $display("FAIL underflow: got %h want %h", obs(), expv());
    end
    step(0, 0, 0, 1);
    n_vec++;
    if (bus.err_sticky !== 1'b0 || obs() !== expv()) begin
      n_err++; $display("FAIL err_clr: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_wrap();
    for (int b = 0; b < 2; b++) begin
      int len = 5 + b;
      for (int i = 0; i < 2 * len; i++) begin
        if (i < len) step(1, 0, $urandom_range(0, 255));
        else step(0, 1, 0);
        n_vec++;
        if (obs() !== expv()) begin
          n_err++; $display("FAIL wrap[%0d.%0d]: got %h want %h", b, i, obs(), expv());
        end
      end
    end
    n_vec++;
    if (bus.count !== 4'd0) begin
      n_err++; $display("FAIL wrap_count: got %0d want 0", bus.count);
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 8; i++) step(1, 0, $urandom_range(0, 255));
    step(1, 1, 'h5c);
    n_vec++;
    if (bus.count !== 4'd8 || bus.fifo_error !== 1'b0 || obs() !== expv()) begin
      n_err++; $display("FAIL simul_full: got %h want %h", obs(), expv());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL simul_drain[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    step(1, 1, 'h3e);
    n_vec++;
    if (bus.count !== 4'd1 || bus.fifo_error !== 1'b1 || obs() !== expv()) begin
      n_err++; $display("FAIL simul_empty: got %h want %h", obs(), expv());
    end
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
  endtask

  task automatic test_thresh();
    step(0, 0, 0, 0, 1, 3, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 'h40 + i);
    n_vec++;
    if (bus.almost_full !== 1'b1 || bus.fifo_pause !== 1'b1 || obs() !== expv()) begin
      n_err++; $display("FAIL thr_set: got %h want %h", obs(), expv());
    end
    step(0, 1, 0);
    n_vec++;
    if (bus.count !== 4'd2 || bus.fifo_pause !== 1'b1 || bus.almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL thr_hold: count=%0d pause=%b af=%b want 2/1/0",
               bus.count, bus.fifo_pause, bus.almost_full);
    end
    step(0, 1, 0);
    n_vec++;
    if (bus.count !== 4'd1 || bus.fifo_pause !== 1'b0 || bus.almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL thr_clear: count=%0d pause=%b ae=%b want 1/0/1",
               bus.count, bus.fifo_pause, bus.almost_empty);
    end
    step(0, 1, 0, 0, 1, AF0, AE0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int wp = (i % 100 < 50) ? 75 : 30;
      bit w = ($urandom_range(0, 99) < wp);
      bit r = ($urandom_range(0, 99) < 100 - wp);
      bit clr = ($urandom_range(0, 9) == 0);
      bit ld = ($urandom_range(0, 19) == 0);
      int af = $urandom_range(3, 9);
      int ae = $urandom_range(0, 2);
      step(w, r, $urandom_range(0, 255), clr, ld, af, ae);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    model_reset();
    step(1, 0, 'ha5);
    n_vec++;
    if (obs() !== expv()) begin
      n_err++; $display("FAIL head_vec: got %h want %h", obs(), expv());
    end
`ifdef FIFO_FWFT_EN
    n_vec++;
    if (bus.data_out_pop !== 8'ha5 || bus.data_valid !== 1'b1) begin
      n_err++; $display("FAIL fwft_head: got %h/%b want a5/1", bus.data_out_pop, bus.data_valid);
    end
`else
    n_vec++;
    if (bus.data_valid !== 1'b0) begin
      n_err++; $display("FAIL reg_head: valid=%b want 0", bus.data_valid);
    end
`endif
    step(1, 1, 'h11);
    step(1, 0, 'h22);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (obs() !== expv() || bus.count !== 4'd0 || bus.fifo_empty !== 1'b1) begin
      n_err++; $display("FAIL async_reset: got %h want %h", obs(), expv());
    end
    #3;
    reset = 1'b1;
  endtask

  initial begin
    bus.write = 0; bus.read = 0; bus.data_in_push = '0; bus.err_clr = 0;
    bus.thr_load = 0; bus.af_thresh_in = '0; bus.ae_thresh_in = '0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_thresh();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
